// File: rtl/dbus_req_ctrl_pkg.sv
// Shared types for the data-bus request controller:
// bus size codes, controller FSM states and the held-request record.
package dbus_req_ctrl_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GRANT = 2'd2
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        wr;
    size_e       size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        discard;
  } hr_t;

endpackage

// File: rtl/dbus_req_ctrl_if.sv
// SRAM-like data bus: request side driven by the controller,
// handshakes and read data returned by the bus.
interface dbus_req_ctrl_if;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size,
    output data_addr, data_wdata,
    input  data_addr_ok, data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size,
    input  data_addr, data_wdata,
    output data_addr_ok, data_data_ok,
    output data_rdata
  );

endinterface

// File: rtl/dbus_req_ctrl_outst_cnt.sv
// Saturating up/down counter with a load port used to snapshot
// the in-flight count when a flush squashes pending responses.
module dbus_outst_cnt #(
  parameter int MAX = 2,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cntNext;

  always_comb begin
    cntNext = cnt;
    if (load) begin
      cntNext = loadVal;
    end else if (inc && !dec) begin
      if (cnt != W'(MAX)) cntNext = cnt + W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) cntNext = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cntNext;
  end

endmodule

// File: rtl/dbus_req_ctrl.sv
// Data-bus request controller: holds one pipeline request on the bus,
// tracks in-flight responses, drops squashed ones, grants cache ops.
module dbus_req_ctrl
  import dbus_req_ctrl_pkg::*;
#(
  parameter int MAX_OUTST = 2,
  parameter int CNT_W     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_req_i,
  input  logic        pipe_wr_i,
  input  logic [1:0]  pipe_size_i,
  input  logic [31:0] pipe_addr_i,
  input  logic [31:0] pipe_wdata_i,
  output logic        pipe_accept_o,
  output logic        pipe_data_ok_o,
  output logic [31:0] pipe_rdata_o,
  input  logic        flush_i,
  input  logic        cop_req_i,
  input  logic        cop_done_i,
  output logic        cop_grant_o,
  output logic        busy_o,
  dbus_req_ctrl_if.master bus
);

  state_e state, stateNext;
  hr_t    hr;

  logic [CNT_W-1:0] outst, disc, snap;
  logic [CNT_W:0]   inFlight;
  logic busAcc, retire, discDec;
  logic latch, drained;

  assign busAcc  = hr.valid && bus.data_addr_ok;
  assign retire  = bus.data_data_ok && (outst != '0);
  assign discDec = bus.data_data_ok && (disc != '0);
  assign snap    = outst + CNT_W'(busAcc) - CNT_W'(retire);

  assign inFlight = {1'b0, outst} + (CNT_W+1)'(hr.valid);

  assign latch = rst && (state == RUN) && pipe_req_i
              && !flush_i && !cop_req_i
              && (!hr.valid || bus.data_addr_ok)
              && (inFlight < (CNT_W+1)'(MAX_OUTST));

  // No new latches in DRAIN, so only the retiring response matters.
  assign drained = !hr.valid
                && ((outst == '0)
                 || (outst == CNT_W'(1) && bus.data_data_ok));

  dbus_outst_cnt #(.MAX(MAX_OUTST), .W(CNT_W)) uOutst (
    .clk     (clk),
    .rst     (rst),
    .inc     (busAcc),
    .dec     (bus.data_data_ok),
    .load    (1'b0),
    .loadVal ('0),
    .cnt     (outst)
  );

  dbus_outst_cnt #(.MAX(MAX_OUTST), .W(CNT_W)) uDisc (
    .clk     (clk),
    .rst     (rst),
    .inc     (busAcc && hr.discard),
    .dec     (discDec),
    .load    (flush_i),
    .loadVal (snap),
    .cnt     (disc)
  );

  // A request already on the bus cannot be withdrawn; mark it instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hr <= '0;
    end else if (latch) begin
      hr.valid   <= 1'b1;
      hr.wr      <= pipe_wr_i;
      hr.size    <= size_e'(pipe_size_i);
      hr.addr    <= pipe_addr_i;
      hr.wdata   <= pipe_wdata_i;
      hr.discard <= 1'b0;
    end else if (busAcc) begin
      hr.valid   <= 1'b0;
      hr.discard <= 1'b0;
    end else if (flush_i && hr.valid) begin
      hr.discard <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      RUN:     if (cop_req_i)  stateNext = DRAIN;
      DRAIN:   if (drained)    stateNext = GRANT;
      GRANT:   if (cop_done_i) stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  assign bus.data_req   = hr.valid;
  assign bus.data_wr    = hr.wr;
  assign bus.data_size  = hr.size;
  assign bus.data_addr  = hr.addr;
  assign bus.data_wdata = hr.wdata;

  assign pipe_accept_o  = latch;
  assign pipe_data_ok_o = rst && bus.data_data_ok
                       && (disc == '0) && !flush_i;
  assign pipe_rdata_o   = bus.data_rdata;
  assign cop_grant_o    = (state == GRANT);
  assign busy_o         = hr.valid || (outst != '0);

  dok_has_owner: assert property (
    @(posedge clk) disable iff (!rst)
    !(bus.data_data_ok && outst == '0));

endmodule

// File: tb/tb_dbus_req_ctrl.sv
// Directed cycle tables plus a mid-transaction async reset
// sequence for the data-bus request controller.
module tb_dbus_req_ctrl;

  logic        clk;
  logic        rst;
  logic        pipe_req_i, pipe_wr_i;
  logic [1:0]  pipe_size_i;
  logic [31:0] pipe_addr_i, pipe_wdata_i;
  logic        pipe_accept_o, pipe_data_ok_o;
  logic [31:0] pipe_rdata_o;
  logic        flush_i, cop_req_i, cop_done_i;
  logic        cop_grant_o, busy_o;

  dbus_req_ctrl_if bus();

  dbus_req_ctrl #(.MAX_OUTST(2), .CNT_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_req_i     (pipe_req_i),
    .pipe_wr_i      (pipe_wr_i),
    .pipe_size_i    (pipe_size_i),
    .pipe_addr_i    (pipe_addr_i),
    .pipe_wdata_i   (pipe_wdata_i),
    .pipe_accept_o  (pipe_accept_o),
    .pipe_data_ok_o (pipe_data_ok_o),
    .pipe_rdata_o   (pipe_rdata_o),
    .flush_i        (flush_i),
    .cop_req_i      (cop_req_i),
    .cop_done_i     (cop_done_i),
    .cop_grant_o    (cop_grant_o),
    .busy_o         (busy_o),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bits: {accept, data_req, data_ok, grant, busy}
  typedef struct {
    logic        req, wr, flush, cop, done, aok, dok;
    logic [31:0] addr, rdata;
    logic [4:0]  exp;
    logic        eWr;
    logic [31:0] eAddr;
  } vec_t;

  vec_t vq[$];
  vec_t vr[$];
  int nChecks = 0;
  int nPass   = 0;

  localparam logic [31:0] A1 = 32'h1FC0_0010;
  localparam logic [31:0] B1 = 32'h0000_1000;
  localparam logic [31:0] B2 = 32'h0000_1004;
  localparam logic [31:0] B3 = 32'h0000_1008;
  localparam logic [31:0] C1 = 32'h0000_2000;
  localparam logic [31:0] C2 = 32'h0000_2004;
  localparam logic [31:0] C3 = 32'h0000_2008;
  localparam logic [31:0] D1 = 32'h0000_3000;
  localparam logic [31:0] F1 = 32'h0000_4000;
  localparam logic [31:0] F2 = 32'h0000_4004;
  localparam logic [31:0] G1 = 32'h0000_5000;
  localparam logic [31:0] G2 = 32'h0000_5004;
  localparam logic [31:0] H1 = 32'h0000_6000;

  function automatic vec_t mk(
    input logic req, wr,
    input logic [31:0] addr,
    input logic flush, cop, done, aok, dok,
    input logic [31:0] rdata,
    input logic [4:0] exp,
    input logic eWr,
    input logic [31:0] eAddr);
    vec_t v;
    v.req = req;   v.wr = wr;     v.addr = addr;
    v.flush = flush; v.cop = cop; v.done = done;
    v.aok = aok;   v.dok = dok;   v.rdata = rdata;
    v.exp = exp;   v.eWr = eWr;   v.eAddr = eAddr;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [4:0] outs();
    return {pipe_accept_o, bus.data_req, pipe_data_ok_o,
            cop_grant_o, busy_o};
  endfunction

  task automatic drive(input vec_t v);
    pipe_req_i       = v.req;
    pipe_wr_i        = v.wr;
    pipe_size_i      = 2'd2;
    pipe_addr_i      = v.addr;
    pipe_wdata_i     = ~v.addr;
    flush_i          = v.flush;
    cop_req_i        = v.cop;
    cop_done_i       = v.done;
    bus.data_addr_ok = v.aok;
    bus.data_data_ok = v.dok;
    bus.data_rdata   = v.rdata;
  endtask

  task automatic applyRow(input vec_t v, input string tag, input int i);
    @(negedge clk);
    drive(v);
    #2;
    chk($sformatf("%s%0d.out", tag, i), 128'(outs()), 128'(v.exp));
    if (v.exp[3])
      chk($sformatf("%s%0d.bus", tag, i),
          128'({bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata}),
          128'({v.eWr, 2'd2, v.eAddr, ~v.eAddr}));
    if (v.exp[2])
      chk($sformatf("%s%0d.rdata", tag, i),
          128'(pipe_rdata_o), 128'(v.rdata));
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0, 0,0,0,0,0, 0, 5'b00000, 0,0);
    rst = 1'b0;
    drive(idle);

    // single load
    vq.push_back(mk(1,0,A1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,0,0, 0, 5'b01001, 0,A1));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,A1));
    vq.push_back(mk(0,0,0,  0,0,0,0,0, 0, 5'b00001, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'hDEADBEEF, 5'b00101, 0,0));
    vq.push_back(idle);
    // back-to-back, third blocked by MAX_OUTST
    vq.push_back(mk(1,0,B1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(1,0,B2, 0,0,0,1,0, 0, 5'b11001, 0,B1));
    vq.push_back(mk(1,0,B3, 0,0,0,1,0, 0, 5'b01001, 0,B2));
    vq.push_back(mk(1,0,B3, 0,0,0,0,0, 0, 5'b00001, 0,0));
    vq.push_back(mk(1,0,B3, 0,0,0,0,1, 32'h11111111, 5'b00101, 0,0));
    vq.push_back(mk(1,0,B3, 0,0,0,0,0, 0, 5'b10001, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,B3));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'h22222222, 5'b00101, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'h33333333, 5'b00101, 0,0));
    vq.push_back(idle);
    // flush with first response: both dropped, then clean load
    vq.push_back(mk(1,0,C1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(1,0,C2, 0,0,0,1,0, 0, 5'b11001, 0,C1));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,C2));
    vq.push_back(mk(0,0,0,  1,0,0,0,1, 32'hAAAA0000, 5'b00001, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'hBBBB0000, 5'b00001, 0,0));
    vq.push_back(mk(1,0,C3, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,C3));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'hCCCC0000, 5'b00101, 0,0));
    vq.push_back(idle);
    // flush while held, addr_ok delayed
    vq.push_back(mk(1,0,D1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(0,0,0,  1,0,0,0,0, 0, 5'b01001, 0,D1));
    vq.push_back(mk(0,0,0,  0,0,0,0,0, 0, 5'b01001, 0,D1));
    vq.push_back(mk(0,0,0,  0,0,0,0,0, 0, 5'b01001, 0,D1));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,D1));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'hEEEE0000, 5'b00001, 0,0));
    vq.push_back(idle);
    // cache-op drain and grant, then a store
    vq.push_back(mk(1,0,F1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,F1));
    vq.push_back(mk(1,1,F2, 0,1,0,0,0, 0, 5'b00001, 0,0));
    vq.push_back(mk(1,1,F2, 0,1,0,0,0, 0, 5'b00001, 0,0));
    vq.push_back(mk(1,1,F2, 0,1,0,0,1, 32'h55550000, 5'b00101, 0,0));
    vq.push_back(mk(1,1,F2, 0,1,0,0,0, 0, 5'b00010, 0,0));
    vq.push_back(mk(1,1,F2, 0,1,1,0,0, 0, 5'b00010, 0,0));
    vq.push_back(mk(1,1,F2, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 1,F2));
    vq.push_back(mk(0,0,0,  0,0,0,0,1, 32'h66660000, 5'b00101, 0,0));
    vq.push_back(idle);
    // leave one outstanding and one held before async reset
    vq.push_back(mk(1,0,G1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vq.push_back(mk(1,0,G2, 0,0,0,1,0, 0, 5'b11001, 0,G1));
    // fresh load after reset
    vr.push_back(mk(1,0,H1, 0,0,0,0,0, 0, 5'b10000, 0,0));
    vr.push_back(mk(0,0,0,  0,0,0,1,0, 0, 5'b01001, 0,H1));
    vr.push_back(mk(0,0,0,  0,0,0,0,1, 32'h77770000, 5'b00101, 0,0));
    vr.push_back(idle);

    @(negedge clk);
    pipe_req_i = 1'b1;
    #2;
    chk("reset.out", 128'(outs()), 128'(0));
    chk("reset.bus",
        128'({bus.data_wr, bus.data_size, bus.data_addr, bus.data_wdata}),
        128'(0));
    @(negedge clk);
    rst = 1'b1;
    drive(idle);

    foreach (vq[i]) applyRow(vq[i], "row", i);

    @(negedge clk);
    drive(idle);
    #1;
    chk("preRst.reqBusy", 128'({bus.data_req, busy_o}), 128'(2'b11));
    rst = 1'b0;
    #1;
    chk("asyncRst.out", 128'(outs()), 128'(0));
    chk("asyncRst.addr", 128'(bus.data_addr), 128'(0));
    pipe_req_i = 1'b1;
    #1;
    chk("asyncRst.accept", 128'(pipe_accept_o), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(idle);

    foreach (vr[i]) applyRow(vr[i], "post", i);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
